// File: rtl/root_stage_controller_if.sv
// root_stage_controller_if: host request/status and child-controller summary signals
// of the root decode sequencer. The controller uses the master view.
interface root_stage_controller_if #(
   parameter int CHILD_FPGA_COUNT        = 2,
   parameter int ITERATION_COUNTER_WIDTH = 8
);
   logic                               start_decode;
   logic [CHILD_FPGA_COUNT-1:0]        child_busy;
   logic [CHILD_FPGA_COUNT-1:0]        child_odd_clusters;
   logic                               decoding_start;
   logic                               next_iteration;
   logic [ITERATION_COUNTER_WIDTH-1:0] iteration_count;
   logic                               decode_done;
   logic                               busy;
   logic                               iteration_overflow;

   modport master (
      input  start_decode, child_busy, child_odd_clusters,
      output decoding_start, next_iteration, iteration_count,
             decode_done, busy, iteration_overflow
   );

   modport slave (
      output start_decode, child_busy, child_odd_clusters,
      input  decoding_start, next_iteration, iteration_count,
             decode_done, busy, iteration_overflow
   );
endinterface

// File: rtl/root_stage_controller.sv
// root_stage_controller: root-level grow/peel decode sequencer over the child controllers.
// Optional macro ITERATION_LIMIT_EN caps grow rounds at MAX_ITERATIONS and flags overflow.
module root_stage_controller #(
   parameter int CHILD_FPGA_COUNT        = 2,
   parameter int ITERATION_COUNTER_WIDTH = 8,
   parameter int MAX_ITERATIONS          = 200,
   parameter int MERGE_SETTLE_CYCLES     = 6,
   parameter int BUSY_QUIET_CYCLES       = 2,
   parameter int PEEL_HOLD_CYCLES        = 6
) (
   input logic                     clk,
   input logic                     reset,
   root_stage_controller_if.master bus
);
   localparam int CW       = ITERATION_COUNTER_WIDTH;
   localparam int SETTLE_W = $clog2(MERGE_SETTLE_CYCLES + 1);
   localparam int QUIET_W  = $clog2(BUSY_QUIET_CYCLES + 1);
   localparam int HOLD_W   = $clog2(PEEL_HOLD_CYCLES + 1);

   localparam logic [SETTLE_W-1:0] SETTLE_MAX = SETTLE_W'(MERGE_SETTLE_CYCLES);
   localparam logic [QUIET_W-1:0]  QUIET_MAX  = QUIET_W'(BUSY_QUIET_CYCLES);
   localparam logic [HOLD_W-1:0]   HOLD_LAST  = HOLD_W'(PEEL_HOLD_CYCLES - 1);
   localparam logic [CW-1:0]       MAX_CNT    = CW'(MAX_ITERATIONS);

`ifdef ITERATION_LIMIT_EN
   localparam bit LIMIT_EN = 1'b1;
`else
   localparam bit LIMIT_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_MERGE,
      ST_DECIDE,
      ST_PEEL,
      ST_FINISH
   } state_t;

   state_t                      state_q, state_d;
   logic [CHILD_FPGA_COUNT-1:0] busy_sync_q, busy_sync_d;
   logic [CHILD_FPGA_COUNT-1:0] odd_sync_q, odd_sync_d;
   logic [SETTLE_W-1:0]         settle_q, settle_d;
   logic [QUIET_W-1:0]          quiet_q, quiet_d;
   logic [HOLD_W-1:0]           hold_q, hold_d;
   logic                        decoding_start_q, decoding_start_d;
   logic                        next_iteration_q, next_iteration_d;
   logic [CW-1:0]               iteration_count_q, iteration_count_d;
   logic                        decode_done_q, decode_done_d;
   logic                        busy_q, busy_d;
   logic                        iteration_overflow_q, iteration_overflow_d;

   logic any_busy;
   logic any_odd;
   logic at_limit;

   // Decisions only ever look at the registered child summaries.
   assign any_busy = |busy_sync_q;
   assign any_odd  = |odd_sync_q;
   assign at_limit = LIMIT_EN && (iteration_count_q == MAX_CNT);

   always_comb begin
      state_d              = state_q;
      busy_sync_d          = bus.child_busy;
      odd_sync_d           = bus.child_odd_clusters;
      settle_d             = settle_q;
      quiet_d              = quiet_q;
      hold_d               = hold_q;
      decoding_start_d     = decoding_start_q;
      next_iteration_d     = next_iteration_q;
      iteration_count_d    = iteration_count_q;
      decode_done_d        = 1'b0;
      iteration_overflow_d = iteration_overflow_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.start_decode) begin
               state_d              = ST_WAIT_MERGE;
               decoding_start_d     = 1'b1;
               next_iteration_d     = 1'b0;
               iteration_count_d    = CW'(1);
               iteration_overflow_d = 1'b0;
               settle_d             = '0;
               quiet_d              = '0;
               hold_d               = '0;
            end
         end

         ST_WAIT_MERGE: begin
            if (settle_q != SETTLE_MAX)
               settle_d = settle_q + 1'b1;
            if (any_busy)
               quiet_d = '0;
            else if (quiet_q != QUIET_MAX)
               quiet_d = quiet_q + 1'b1;
            if ((settle_q == SETTLE_MAX) && (quiet_q >= QUIET_MAX))
               state_d = ST_DECIDE;
         end

         ST_DECIDE: begin
            settle_d = '0;
            quiet_d  = '0;
            hold_d   = '0;
            if (any_odd && !at_limit) begin
               next_iteration_d  = ~next_iteration_q;
               iteration_count_d = iteration_count_q + 1'b1;
               state_d           = ST_WAIT_MERGE;
            end else begin
               // Odd clusters left at the limit means a forced, not natural, finish.
               if (any_odd)
                  iteration_overflow_d = 1'b1;
               decoding_start_d = 1'b0;
               state_d          = ST_PEEL;
            end
         end

         ST_PEEL: begin
            decoding_start_d = 1'b0;
            if (hold_q == HOLD_LAST) begin
               next_iteration_d = 1'b1;
               decode_done_d    = 1'b1;
               state_d          = ST_FINISH;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end

         ST_FINISH: begin
            // Children start the next decode from a 0 reference.
            next_iteration_d = 1'b0;
            state_d          = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q              <= ST_IDLE;
         busy_sync_q          <= '0;
         odd_sync_q           <= '0;
         settle_q             <= '0;
         quiet_q              <= '0;
         hold_q               <= '0;
         decoding_start_q     <= 1'b0;
         next_iteration_q     <= 1'b0;
         iteration_count_q    <= '0;
         decode_done_q        <= 1'b0;
         busy_q               <= 1'b0;
         iteration_overflow_q <= 1'b0;
      end else begin
         state_q              <= state_d;
         busy_sync_q          <= busy_sync_d;
         odd_sync_q           <= odd_sync_d;
         settle_q             <= settle_d;
         quiet_q              <= quiet_d;
         hold_q               <= hold_d;
         decoding_start_q     <= decoding_start_d;
         next_iteration_q     <= next_iteration_d;
         iteration_count_q    <= iteration_count_d;
         decode_done_q        <= decode_done_d;
         busy_q               <= busy_d;
         iteration_overflow_q <= iteration_overflow_d;
      end
   end

   assign bus.decoding_start     = decoding_start_q;
   assign bus.next_iteration     = next_iteration_q;
   assign bus.iteration_count    = iteration_count_q;
   assign bus.decode_done        = decode_done_q;
   assign bus.busy               = busy_q;
   assign bus.iteration_overflow = iteration_overflow_q;
endmodule
